// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC generation, req/gnt/rvalid memory interface,
// in-order instruction FIFO and branch/jump redirect handling.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_four_o,
    input  logic        instr_ready_i,
    output logic        fetch_err_o
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] resp_pc_q, resp_pc_d;
    cnt_t        count_q, count_d;
    cnt_t        outst_q, outst_d;
    cnt_t        kill_q, kill_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    ptr_t        wr_ptr_q, wr_ptr_d;
    logic        run_q;
    logic        err_q, err_d;
    logic [31:0] instr_mem_q [DEPTH];
    logic [31:0] pc_mem_q [DEPTH];

    logic        req;
    logic        issue;
    logic        resp;
    logic        push;
    logic        pop;
    logic [CW:0] credit_used;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? ptr_t'(0) : p + ptr_t'(1);
    endfunction

    // Credits count killed requests too: they still occupy a slot until they return.
    assign credit_used = {1'b0, count_q} + {1'b0, outst_q};
    assign req         = run_q && !err_q && (credit_used < DEPTH_C);
    assign issue       = req && imem_gnt_i;
    assign resp        = imem_rvalid_i && (outst_q != '0);
    assign push        = resp && (kill_q == '0) && !redirect_i;
    assign pop         = (count_q != '0) && instr_ready_i && !redirect_i;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q;
        outst_d    = outst_q + cnt_t'(issue) - cnt_t'(resp);
        kill_d     = kill_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        err_d      = err_q;

        if (redirect_i) begin
            // Everything still in flight, including this cycle's grant, is from the old stream.
            fetch_pc_d = redirect_pc_i;
            resp_pc_d  = redirect_pc_i;
            count_d    = '0;
            kill_d     = outst_d;
            wr_ptr_d   = rd_ptr_q;
            err_d      = (redirect_pc_i[1:0] != 2'b00);
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (resp && (kill_q != '0)) begin
                kill_d = kill_q - cnt_t'(1);
            end
            if (push) begin
                resp_pc_d = resp_pc_q + 32'd4;
                wr_ptr_d  = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + cnt_t'(push) - cnt_t'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            kill_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            run_q      <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            kill_q     <= kill_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            run_q      <= 1'b1;
            err_q      <= err_d;
            if (push) begin
                instr_mem_q[wr_ptr_q] <= imem_rdata_i;
                pc_mem_q[wr_ptr_q]    <= resp_pc_q;
            end
        end
    end

    assign imem_req_o    = req;
    assign imem_addr_o   = fetch_pc_q;
    assign instr_valid_o = (count_q != '0);
    assign instr_o       = instr_mem_q[rd_ptr_q];
    assign pc_o          = pc_mem_q[rd_ptr_q];
    assign pc_four_o     = pc_o + 32'd4;
    assign fetch_err_o   = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle table with a simple in-order memory
// responder, plus hand-written reset and stray-response sequences.
module tb_fetch_unit;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_four_o;
    logic        instr_ready_i;
    logic        fetch_err_o;

    always #5 clk_i = ~clk_i;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i(imem_rdata_i),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o),
        .pc_o(pc_o), .pc_four_o(pc_four_o),
        .instr_ready_i(instr_ready_i), .fetch_err_o(fetch_err_o)
    );

    typedef struct {
        logic        rdy;
        logic        gnt;
        logic        rv;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
        logic        e_err;
    } vec_t;

    vec_t        tv[$];
    logic [31:0] mq[$];
    logic        gnt_en;
    logic        rv_en;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
    endfunction

    function automatic void add(input logic rdy, input logic gnt, input logic rv,
                                input logic redir, input logic [31:0] rpc,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_vld, input logic [31:0] e_pc,
                                input logic e_err);
        vec_t v;
        v = '{rdy, gnt, rv, redir, rpc, e_req, e_addr, e_vld, e_pc, e_err};
        tv.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_mem();
        imem_gnt_i    = imem_req_o && gnt_en;
        imem_rvalid_i = rv_en && (mq.size() > 0);
        imem_rdata_i  = 32'h0;
        if (imem_rvalid_i) imem_rdata_i = mem_word(mq[0]);
    endtask

    task automatic tick();
        if (imem_rvalid_i && (mq.size() > 0)) void'(mq.pop_front());
        if (imem_req_o && imem_gnt_i) mq.push_back(imem_addr_o);
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " req"},   {31'b0, imem_req_o},    32'h0);
        chk({tag, " vld"},   {31'b0, instr_valid_o}, 32'h0);
        chk({tag, " instr"}, instr_o,                32'h0);
        chk({tag, " pc"},    pc_o,                   32'h0);
        chk({tag, " pc4"},   pc_four_o,              32'h4);
        chk({tag, " err"},   {31'b0, fetch_err_o},   32'h0);
    endtask

    initial begin
        rst_ni        = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        instr_ready_i = 1'b1;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        gnt_en        = 1'b1;
        rv_en         = 1'b1;

        // rdy gnt rv redir rpc | e_req e_addr | e_vld e_pc | e_err
        add(1,1,1,0,32'h0,   1,32'h0,   0,32'h0,   0);
        add(1,1,1,0,32'h0,   1,32'h4,   0,32'h0,   0);
        add(1,1,1,0,32'h0,   0,32'h0,   1,32'h0,   0);
        add(1,1,1,0,32'h0,   1,32'h8,   1,32'h4,   0);
        add(1,1,1,0,32'h0,   1,32'hC,   0,32'h0,   0);
        add(1,1,1,0,32'h0,   0,32'h0,   1,32'h8,   0);
        add(1,1,1,0,32'h0,   1,32'h10,  1,32'hC,   0);
        // decode stalls for 10 cycles
        add(0,1,1,0,32'h0,   1,32'h14,  0,32'h0,   0);
        add(0,1,1,0,32'h0,   0,32'h0,   1,32'h10,  0);
        for (int i = 0; i < 8; i++) add(0,1,1,0,32'h0, 0,32'h0, 1,32'h10, 0);
        add(1,1,1,0,32'h0,   0,32'h0,   1,32'h10,  0);
        add(1,1,1,0,32'h0,   1,32'h18,  1,32'h14,  0);
        add(1,1,1,0,32'h0,   1,32'h1C,  0,32'h0,   0);
        add(1,1,1,0,32'h0,   0,32'h0,   1,32'h18,  0);
        add(1,1,1,0,32'h0,   1,32'h20,  1,32'h1C,  0);
        // grant withheld 3 cycles
        add(1,0,1,0,32'h0,   1,32'h24,  0,32'h0,   0);
        add(1,0,1,0,32'h0,   1,32'h24,  1,32'h20,  0);
        add(1,0,1,0,32'h0,   1,32'h24,  0,32'h0,   0);
        add(1,1,1,0,32'h0,   1,32'h24,  0,32'h0,   0);
        add(1,1,1,0,32'h0,   1,32'h28,  0,32'h0,   0);
        add(1,1,1,0,32'h0,   0,32'h0,   1,32'h24,  0);
        add(1,1,1,0,32'h0,   1,32'h2C,  1,32'h28,  0);
        // redirect to 0x100 with two requests in flight
        add(1,1,0,0,32'h0,   1,32'h30,  0,32'h0,   0);
        add(1,1,0,1,32'h100, 0,32'h0,   0,32'h0,   0);
        add(1,1,1,0,32'h0,   0,32'h0,   0,32'h0,   0);
        add(1,1,1,0,32'h0,   1,32'h100, 0,32'h0,   0);
        add(1,1,1,0,32'h0,   1,32'h104, 0,32'h0,   0);
        add(1,1,1,0,32'h0,   0,32'h0,   1,32'h100, 0);
        add(1,1,1,0,32'h0,   1,32'h108, 1,32'h104, 0);
        // misaligned redirect, then aligned recovery
        add(1,1,1,1,32'h102, 1,32'h10C, 0,32'h0,   0);
        add(1,1,1,0,32'h0,   0,32'h0,   0,32'h0,   1);
        add(1,1,1,0,32'h0,   0,32'h0,   0,32'h0,   1);
        add(1,1,1,1,32'h200, 0,32'h0,   0,32'h0,   1);
        add(1,1,1,0,32'h0,   1,32'h200, 0,32'h0,   0);
        add(1,1,1,0,32'h0,   1,32'h204, 0,32'h0,   0);
        add(1,1,1,0,32'h0,   0,32'h0,   1,32'h200, 0);
        add(1,1,1,0,32'h0,   1,32'h208, 1,32'h204, 0);
        // wrap at the top of the address space
        add(1,1,1,1,32'hFFFF_FFFC, 1,32'h20C, 0,32'h0, 0);
        add(1,1,1,0,32'h0,   1,32'hFFFF_FFFC, 0,32'h0, 0);
        add(1,1,1,0,32'h0,   1,32'h0,   0,32'h0,   0);
        add(1,1,1,0,32'h0,   0,32'h0,   1,32'hFFFF_FFFC, 0);
        add(1,1,1,0,32'h0,   1,32'h4,   1,32'h0,   0);

        drive_mem();
        tick();
        drive_mem();
        #1;
        chk_reset("reset");

        rst_ni = 1'b1;
        tick();

        for (int i = 0; i < tv.size(); i++) begin
            instr_ready_i = tv[i].rdy;
            gnt_en        = tv[i].gnt;
            rv_en         = tv[i].rv;
            redirect_i    = tv[i].redir;
            redirect_pc_i = tv[i].rpc;
            drive_mem();
            #1;
            chk($sformatf("row%0d req", i), {31'b0, imem_req_o},    {31'b0, tv[i].e_req});
            chk($sformatf("row%0d vld", i), {31'b0, instr_valid_o}, {31'b0, tv[i].e_vld});
            chk($sformatf("row%0d err", i), {31'b0, fetch_err_o},   {31'b0, tv[i].e_err});
            if (tv[i].e_req) chk($sformatf("row%0d addr", i), imem_addr_o, tv[i].e_addr);
            if (tv[i].e_vld) begin
                chk($sformatf("row%0d pc", i),    pc_o,      tv[i].e_pc);
                chk($sformatf("row%0d pc4", i),   pc_four_o, tv[i].e_pc + 32'd4);
                chk($sformatf("row%0d instr", i), instr_o,   mem_word(tv[i].e_pc));
            end
            tick();
        end
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        instr_ready_i = 1'b1;
        gnt_en        = 1'b1;
        rv_en         = 1'b1;

        // reset in the middle of the stream, one request still in flight
        rst_ni = 1'b0;
        drive_mem();
        tick();
        mq.delete();
        drive_mem();
        #1;
        chk_reset("midreset");
        rst_ni = 1'b1;
        tick();

        // stray response while nothing is outstanding must be ignored
        drive_mem();
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hBAD0_BAD0;
        #1;
        chk("restart req",  {31'b0, imem_req_o}, 32'h1);
        chk("restart addr", imem_addr_o,         32'h0);
        tick();
        drive_mem();
        #1;
        chk("restart2 addr", imem_addr_o,           32'h4);
        chk("restart2 vld",  {31'b0, instr_valid_o}, 32'h0);
        tick();
        drive_mem();
        #1;
        chk("restart3 vld",   {31'b0, instr_valid_o}, 32'h1);
        chk("restart3 pc",    pc_o,                   32'h0);
        chk("restart3 instr", instr_o,                mem_word(32'h0));
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
